// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline EX stage and the multiply/divide unit.
// The pipeline is the master: it raises start for one cycle when busy is low; done pulses with the new HI/LO.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             Sign;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, Sign, in1, in2,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, Sign, in1, in2,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO: one radix-2 step per cycle on operand magnitudes,
// signs applied in a final FIX cycle. mthi/mtlo write in a single cycle while idle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    a_neg = bus.Sign & bus.in1[WIDTH-1];
    b_neg = bus.Sign & bus.in2[WIDTH-1];
    a_mag = a_neg ? (~bus.in1 + 1'b1) : bus.in1;
    b_mag = b_neg ? (~bus.in2 + 1'b1) : bus.in2;

    // Multiply: acc = {partial, multiplier}; add multiplicand on the low bit, shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift left, keep the subtraction if it fits.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    div_next = (rem_sh >= {1'b0, opnd_q}) ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                                          : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    dvd_d     = dvd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op[1]) begin
            if (bus.op[0]) lo_d = bus.in1;
            else           hi_d = bus.in1;
          end else begin
            is_div_d  = bus.op[0];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = bus.op[0] & (bus.in2 == '0);
            dvd_d     = bus.in1;
            opnd_d    = bus.op[0] ? b_mag : a_mag;
            acc_d     = {{WIDTH{1'b0}}, (bus.op[0] ? a_mag : b_mag)};
            cnt_d     = CW'(WIDTH);
            busy_d    = 1'b1;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      dvd_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      dvd_q     <= dvd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;
endmodule
